// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbitration of REQ_NUM byte requesters onto one UART transmitter.
// Requesters get accept/done/timeout pulses.
module uart_tx_arbiter #(
  parameter int REQ_NUM = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQ_NUM-1:0]   req_valid,
  input  logic [REQ_NUM*8-1:0] req_data,
  output logic [REQ_NUM-1:0]   req_ready,
  output logic [REQ_NUM-1:0]   req_done,
  output logic [REQ_NUM-1:0]   req_err,
  output logic                 send_start,
  output logic [7:0]           send_data,
  input  logic                 send_busy,
  input  logic                 send_finish,
  output logic [REQ_NUM-1:0]   grant
);
  localparam int IW = $clog2(REQ_NUM);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t               state_q;
  logic [IW-1:0]        last_q, win_d, idx;
  logic [CW-1:0]        cnt_q;
  logic [REQ_NUM-1:0]   grant_q, ready_q, done_q, err_q, onehot_d;
  logic                 start_q;
  logic [7:0]           data_q;
  // Scan from lowest to highest priority so the nearest valid index after last_q wins.
  always_comb begin
    win_d = '0;
    idx = '0;
    for (int k = REQ_NUM; k > 0; k--) begin
      idx = IW'((int'(last_q) + k) % REQ_NUM);
      if (req_valid[idx]) win_d = idx;
    end
  end
  assign onehot_d = REQ_NUM'(1) << win_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= IW'(REQ_NUM - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      ready_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      start_q <= 1'b0;
      ready_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      case (state_q)
        IDLE: if (|req_valid && !send_busy) begin
          state_q <= START;
          last_q  <= win_d;
          grant_q <= onehot_d;
          ready_q <= onehot_d;
          start_q <= 1'b1;
          data_q  <= req_data[{win_d, 3'b000} +: 8];
        end
        START: begin
          state_q <= WAIT;
          cnt_q   <= '0;
        end
        WAIT: if (send_finish) begin
          state_q <= IDLE;
          done_q  <= grant_q;
          grant_q <= '0;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_q <= IDLE;
          err_q   <= grant_q;
          grant_q <= '0;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready  = ready_q;
  assign req_done   = done_q;
  assign req_err    = err_q;
  assign send_start = start_q;
  assign send_data  = data_q;
  assign grant      = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with a queue scoreboard of expected output events.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = 32'hC3_3C_A1_55;
  logic [3:0]  req_ready, req_done, req_err, grant;
  logic        send_start, send_busy = 1'b0, send_finish = 1'b0;
  logic [7:0]  send_data;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  ld = '0;
  typedef struct {
    int          c;
    logic [24:0] v;
  } exp_t;
  exp_t q[$];

  uart_tx_arbiter #(.REQ_NUM(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .req_done(req_done), .req_err(req_err),
    .send_start(send_start), .send_data(send_data), .send_busy(send_busy),
    .send_finish(send_finish), .grant(grant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle with a strobe or pulse must match the next queued event.
  always @(negedge clk) begin
    if (send_start || |req_done || |req_err) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_event cyc=%0d got=%h", cyc, {send_start, req_ready, req_done, req_err, grant, send_data});
      end else begin
        exp_t e;
        e = q.pop_front();
        if (e.c != cyc || e.v !== {send_start, req_ready, req_done, req_err, grant, send_data}) begin
          miscompares++;
          $display("FAIL event cyc=%0d got=%h want cyc=%0d val=%h", cyc,
                   {send_start, req_ready, req_done, req_err, grant, send_data}, e.c, e.v);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_start(input int w);
    logic [3:0] oh;
    exp_t e;
    oh = 4'b0001 << w;
    ld = req_data[w*8 +: 8];
    e.c = cyc + 1;
    e.v = {1'b1, oh, 4'b0, 4'b0, oh, ld};
    q.push_back(e);
  endtask

  task automatic push_end(input int w, input int dly, input logic is_err);
    logic [3:0] oh;
    exp_t e;
    oh = 4'b0001 << w;
    e.c = cyc + dly;
    e.v = {1'b0, 4'b0, is_err ? 4'b0 : oh, is_err ? oh : 4'b0, 4'b0, ld};
    q.push_back(e);
  endtask

  task automatic check_quiet(input string name, input logic [7:0] d);
    vectors++;
    if ({send_start, req_ready, req_done, req_err, grant, send_data} !== {17'b0, d}) begin
      miscompares++;
      $display("FAIL %s got=%h want=%h", name, {send_start, req_ready, req_done, req_err, grant, send_data}, {17'b0, d});
    end
  endtask

  // One transfer: winner w, finish after wt extra WAIT cycles, valid becomes v_after once accepted.
  task automatic xfer(input logic [3:0] v, input int w, input int wt, input logic [3:0] v_after);
    req_valid = v;
    push_start(w);
    tick;
    req_valid = v_after;
    tick;
    repeat (wt) tick;
    send_finish = 1'b1;
    push_end(w, 1, 1'b0);
    tick;
    send_finish = 1'b0;
  endtask

  initial begin
    repeat (2) tick;
    check_quiet("reset_state", 8'h00);
    rst = 1'b0;
    tick;
    check_quiet("idle_after_reset", 8'h00);
    // Contention: round robin 0,1,2,3,0 back-to-back.
    for (int t = 0; t < 5; t++) xfer(4'hf, t % 4, 0, (t == 4) ? 4'h0 : 4'hf);
    tick;
    // Single request.
    xfer(4'h1, 0, 2, 4'h0);
    tick;
    check_quiet("idle_after_single", 8'h55);
    // Spurious finish in IDLE.
    send_finish = 1'b1;
    tick;
    send_finish = 1'b0;
    check_quiet("spurious_finish_a", 8'h55);
    tick;
    check_quiet("spurious_finish_b", 8'h55);
    // Busy blocks the grant.
    send_busy = 1'b1;
    req_valid = 4'h2;
    repeat (5) begin
      tick;
      check_quiet("busy_block", 8'h55);
    end
    send_busy = 1'b0;
    xfer(4'h2, 1, 1, 4'h0);
    tick;
    // Timeout: no finish, err after counter reaches 8.
    req_valid = 4'h4;
    push_start(2);
    tick;
    req_valid = 4'h0;
    tick;
    push_end(2, 9, 1'b1);
    repeat (10) tick;
    check_quiet("idle_after_timeout", 8'h3c);
    // Finish coincides with count 8: done only.
    xfer(4'h8, 3, 8, 4'h0);
    tick;
    // Reset in WAIT aborts silently, priority returns to index 0.
    req_valid = 4'h2;
    push_start(1);
    tick;
    req_valid = 4'h0;
    repeat (2) tick;
    rst = 1'b1;
    tick;
    check_quiet("reset_mid_wait", 8'h00);
    rst = 1'b0;
    repeat (3) tick;
    check_quiet("quiet_after_reset", 8'h00);
    xfer(4'hf, 0, 0, 4'h0);
    repeat (3) tick;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL missing_events got=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter REQ_NUM, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter TIMEOUT, default 65535, maximum cycles to wait for send_finish after send_start.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req_valid  input  REQ_NUM  bit i high: requester i has a byte pending; held with req_data until req_ready[i].
REQ-006 req_data  input  REQ_NUM*8  byte of requester i at bits [8i+7:8i].
REQ-007 req_ready  output  REQ_NUM  one-cycle pulse: requester i's byte accepted.
REQ-008 req_done  output  REQ_NUM  one-cycle pulse: requester i's byte fully transmitted.
REQ-009 req_err  output  REQ_NUM  one-cycle pulse: requester i's byte timed out.
REQ-010 send_start  output  1  one-cycle start strobe to the UART transmitter.
REQ-011 send_data  output  8  byte to the transmitter, stable from send_start until completion.
REQ-012 send_busy  input  1  transmitter busy.
REQ-013 send_finish  input  1  transmitter completion pulse.
REQ-014 grant  output  REQ_NUM  one-hot owner of the transmitter, zero when idle.

Function
REQ-015 All outputs registered; FSM states IDLE, START, WAIT.
REQ-016 IDLE: if any req_valid and send_busy=0, select winner by round-robin, latch its req_data into send_data, set grant, go START; otherwise stay IDLE.
REQ-017 Round-robin: search starts at index (last_winner+1) mod REQ_NUM and wraps; last_winner resets to REQ_NUM-1, so index 0 has first priority after reset.
REQ-018 IDLE with req_valid set and send_busy=1: no grant, stay IDLE, no pulses.
REQ-019 START (one cycle): send_start=1, req_ready[winner]=1, send_data holds latched byte; go WAIT; timeout counter cleared.
REQ-020 Latency: req_valid sampled in IDLE at cycle N -> send_start and req_ready at N+1.
REQ-021 WAIT: counter increments each cycle; send_finish=1 -> next cycle req_done[winner]=1, grant=0, go IDLE.
REQ-022 WAIT: counter reaching TIMEOUT without send_finish -> next cycle req_err[winner]=1, grant=0, go IDLE; send_finish and timeout in the same cycle count as finish (no err).
REQ-023 send_finish in IDLE or START is ignored.
REQ-024 req_valid changes outside IDLE do not affect the current transfer; a requester dropping req_valid before req_ready simply loses its slot.
REQ-025 Back-to-back: the IDLE cycle following req_done/req_err may grant again, giving a minimum period of 3 cycles plus transmitter time per byte.
REQ-026 Counter width is clog2(TIMEOUT+1); the counter does not wrap.
REQ-027 send_data is not changed except in IDLE on a grant.

Reset
REQ-028 rst=1 at a clock edge: state IDLE, send_start=0, send_data=0, grant=0, req_ready=req_done=req_err=0, counter=0, last_winner=REQ_NUM-1.
REQ-029 Reset mid-transfer aborts without any req_done or req_err pulse; the transmitter is not otherwise signalled.

Verification
REQ-030 Single request: req_valid=0001, data 0x55 -> send_start and req_ready=0001 one cycle later, send_data=0x55; send_finish -> req_done=0001 next cycle.
REQ-031 Contention: req_valid=1111 held, finish after every start -> winners in order 0,1,2,3,0, each with matching send_data.
REQ-032 Busy block: req_valid=0010, send_busy=1 for 5 cycles -> no send_start until the cycle after send_busy falls.
REQ-033 Timeout with TIMEOUT=8 and no send_finish -> req_err pulses for the owner, no req_done, then IDLE; same-cycle finish at count 8 -> req_done only.
REQ-034 Reset asserted in WAIT -> all outputs 0 next cycle, no done/err; next request from index 0 wins first.
REQ-035 Spurious send_finish in IDLE -> no output change.
